// File: rtl/wb_trace_serializer_pkg.sv
// Shared types for the writeback trace serializer: the buffered trace entry
// and the helper that builds one from a writeback slot.
package wb_trace_serializer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_entry_t;

  // Writes to r0 are architecturally invisible, so their enable is cleared on entry.
  function automatic trace_entry_t make_entry(
    input logic [31:0] pc,
    input logic        wen,
    input logic [4:0]  waddr,
    input logic [31:0] wdata
  );
    trace_entry_t e;
    e.pc    = pc;
    e.wen   = wen && (waddr != 5'd0);
    e.waddr = waddr;
    e.wdata = wdata;
    return e;
  endfunction

endpackage

// File: rtl/wb_trace_serializer_fifo.sv
// Two-write / one-read FIFO of trace entries. Writes that do not fit are
// dropped youngest-first (data1 before data0) and reported on overflow.
module trace_fifo
  import wb_trace_serializer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push0,
  input  logic                     push1,
  input  trace_entry_t             data0,
  input  trace_entry_t             data1,
  input  logic                     pop,
  output trace_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   wr_ptr_1;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   free;
  logic [CW-1:0]   n_req;
  logic [CW-1:0]   n_acc;

  // A full FIFO accepts nothing, even when the head is leaving this cycle.
  always_comb begin
    free  = (count_q == CW'(DEPTH)) ? '0 : CW'(DEPTH) - count_q + CW'(pop);
    n_req = CW'(push0) + CW'(push1);
    n_acc = (n_req > free) ? free : n_req;
  end

  assign wr_ptr_1 = wr_ptr + AW'(1);
  assign overflow = (n_req > free);
  assign head     = mem[rd_ptr];
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (n_acc >= CW'(1)) mem[wr_ptr]   <= data0;
    if (n_acc == CW'(2)) mem[wr_ptr_1] <= data1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(n_acc);
      rd_ptr  <= rd_ptr + AW'(pop);
      count_q <= count_q + n_acc - CW'(pop);
    end
  end

endmodule

// File: rtl/wb_trace_serializer.sv
// Serializes dual-issue writeback commits onto a single-commit debug trace
// port in program order, bypassing the FIFO when it is empty.
module wb_trace_serializer
  import wb_trace_serializer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        W_master_valid,
  input  logic [31:0] W_master_pc,
  input  logic        W_master_reg_wen,
  input  logic [4:0]  W_master_reg_waddr,
  input  logic [31:0] W_master_reg_wdata,
  input  logic        W_slave_valid,
  input  logic [31:0] W_slave_pc,
  input  logic        W_slave_reg_wen,
  input  logic [4:0]  W_slave_reg_waddr,
  input  logic [31:0] W_slave_reg_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic        trace_stall,
  output logic        trace_overflow
);
  localparam int CW = $clog2(DEPTH) + 1;

  trace_entry_t  m_entry, s_entry, out_entry, head, data0, data1;
  logic          push0, push1, pop, drop;
  logic [CW-1:0] count;

  // Oldest-first selection: FIFO head, then master, then slave.
  always_comb begin
    m_entry   = make_entry(W_master_pc, W_master_reg_wen, W_master_reg_waddr, W_master_reg_wdata);
    s_entry   = make_entry(W_slave_pc, W_slave_reg_wen, W_slave_reg_waddr, W_slave_reg_wdata);
    pop       = (count != '0);
    out_entry = '0;
    push0     = 1'b0;
    push1     = 1'b0;
    data0     = m_entry;
    data1     = s_entry;
    if (pop) begin
      out_entry = head;
      push0     = W_master_valid | W_slave_valid;
      push1     = W_master_valid & W_slave_valid;
      data0     = W_master_valid ? m_entry : s_entry;
    end else if (W_master_valid) begin
      out_entry = m_entry;
      push0     = W_slave_valid;
      data0     = s_entry;
    end else if (W_slave_valid) begin
      out_entry = s_entry;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push0    (push0),
    .push1    (push1),
    .data0    (data0),
    .data1    (data1),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .overflow (drop)
  );

  assign trace_stall = (count >= CW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
      trace_overflow    <= 1'b0;
    end else begin
      debug_wb_pc       <= out_entry.pc;
      debug_wb_rf_wen   <= {4{out_entry.wen}};
      debug_wb_rf_wnum  <= out_entry.waddr;
      debug_wb_rf_wdata <= out_entry.wdata;
      if (drop) trace_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Scoreboard bench for wb_trace_serializer: the driver queues expected traces,
// the monitor compares every non-idle trace cycle against the queue head.
module tb_wb_trace_serializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        W_master_valid, W_master_reg_wen, W_slave_valid, W_slave_reg_wen;
  logic [31:0] W_master_pc, W_master_reg_wdata, W_slave_pc, W_slave_reg_wdata;
  logic [4:0]  W_master_reg_waddr, W_slave_reg_waddr;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic        trace_stall, trace_overflow;

  always #5 clk = ~clk;

  wb_trace_serializer #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .W_master_valid(W_master_valid), .W_master_pc(W_master_pc),
    .W_master_reg_wen(W_master_reg_wen), .W_master_reg_waddr(W_master_reg_waddr),
    .W_master_reg_wdata(W_master_reg_wdata),
    .W_slave_valid(W_slave_valid), .W_slave_pc(W_slave_pc),
    .W_slave_reg_wen(W_slave_reg_wen), .W_slave_reg_waddr(W_slave_reg_waddr),
    .W_slave_reg_wdata(W_slave_reg_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .trace_stall(trace_stall), .trace_overflow(trace_overflow)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   dual   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (rst_n && debug_wb_pc !== 32'h0) begin
      exp_t got, want;
      got = {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL trace: unexpected pc=%h wen=%h wnum=%0d wdata=%h, required no trace",
                 got.pc, got.wen, got.wnum, got.wdata);
      end else begin
        want = exp_q.pop_front();
        if (got === want) begin
          passes++;
          $display("trace pc=%h wen=%h wnum=%0d wdata=%h ok", got.pc, got.wen, got.wnum, got.wdata);
        end else begin
          $display("FAIL trace: got pc=%h wen=%h wnum=%0d wdata=%h required pc=%h wen=%h wnum=%0d wdata=%h",
                   got.pc, got.wen, got.wnum, got.wdata, want.pc, want.wen, want.wnum, want.wdata);
        end
      end
    end
  end

  task automatic idle();
    W_master_valid = 1'b0; W_master_pc = '0; W_master_reg_wen = 1'b0;
    W_master_reg_waddr = '0; W_master_reg_wdata = '0;
    W_slave_valid = 1'b0; W_slave_pc = '0; W_slave_reg_wen = 1'b0;
    W_slave_reg_waddr = '0; W_slave_reg_wdata = '0;
  endtask

  task automatic set_m(input logic [31:0] pc, input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    W_master_valid = 1'b1; W_master_pc = pc; W_master_reg_wen = wen;
    W_master_reg_waddr = wa; W_master_reg_wdata = wd;
  endtask

  task automatic set_s(input logic [31:0] pc, input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    W_slave_valid = 1'b1; W_slave_pc = pc; W_slave_reg_wen = wen;
    W_slave_reg_waddr = wa; W_slave_reg_wdata = wd;
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic [3:0] wen, input logic [4:0] wn, input logic [31:0] wd);
    exp_q.push_back({pc, wen, wn, wd});
  endtask

  // Dual commit k: master wen alternates, all destinations nonzero.
  task automatic pair(input int k, input bit record);
    logic [31:0] pc;
    pc = 32'h1000_0000 + 32'(k) * 8;
    set_m(pc, k[0], 5'(1 + k % 30), pc ^ 32'h00A5_0000);
    set_s(pc + 32'd4, 1'b1, 5'(2 + k % 29), ~pc);
    if (record) begin
      exp_push(pc, k[0] ? 4'hF : 4'h0, 5'(1 + k % 30), pc ^ 32'h00A5_0000);
      exp_push(pc + 32'd4, 4'hF, 5'(2 + k % 29), ~pc);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pc", debug_wb_pc, 32'h0);
    check("rst_wen", 32'(debug_wb_rf_wen), 32'h0);
    check("rst_stall", 32'(trace_stall), 32'h0);
    check("rst_ovf", 32'(trace_overflow), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    set_m(32'hBFC0_0000, 1'b1, 5'd8, 32'h1234);
    exp_push(32'hBFC0_0000, 4'hF, 5'd8, 32'h1234);
    @(negedge clk); idle();
    check("single_latency", debug_wb_pc, 32'hBFC0_0000);
    @(negedge clk);
    check("single_idle", debug_wb_pc, 32'h0);

    set_m(32'h100, 1'b1, 5'd3, 32'hAAAA);
    set_s(32'h104, 1'b1, 5'd0, 32'h5555);
    exp_push(32'h100, 4'hF, 5'd3, 32'hAAAA);
    exp_push(32'h104, 4'h0, 5'd0, 32'h5555);
    @(negedge clk); idle();
    check("dual_first", debug_wb_pc, 32'h100);
    @(negedge clk);
    check("dual_second", debug_wb_pc, 32'h104);
    check("dual_r0_wen", 32'(debug_wb_rf_wen), 32'h0);
    @(negedge clk);
    check("dual_idle", debug_wb_pc, 32'h0);

    set_s(32'h200, 1'b1, 5'd31, 32'hDEAD);
    exp_push(32'h200, 4'hF, 5'd31, 32'hDEAD);
    @(negedge clk); idle();
    check("slave_only", debug_wb_pc, 32'h200);
    @(negedge clk);

    // Sustained dual issue obeying stall: from empty, count reaches 7 after 7 pairs.
    for (int c = 0; c < 20 && !trace_stall; c++) begin
      pair(c, 1'b1);
      dual++;
      @(negedge clk);
    end
    idle();
    check("stall_rise_pairs", 32'(dual), 32'd7);
    check("stall_high", 32'(trace_stall), 32'h1);
    repeat (10) @(negedge clk);
    check("sust_stall_low", 32'(trace_stall), 32'h0);
    check("sust_no_ovf", 32'(trace_overflow), 32'h0);
    check("sust_drained", 32'(exp_q.size()), 32'h0);

    // Ignore stall: 8 pairs fill the FIFO exactly, the 9th pair is dropped entirely.
    for (int c = 0; c < 9; c++) begin
      if (c == 8) check("ovf_before", 32'(trace_overflow), 32'h0);
      pair(100 + c, c < 8);
      @(negedge clk);
    end
    idle();
    check("ovf_set", 32'(trace_overflow), 32'h1);
    repeat (12) @(negedge clk);
    check("ovf_sticky", 32'(trace_overflow), 32'h1);
    check("ovf_drained", 32'(exp_q.size()), 32'h0);

    // Reset mid-burst with the FIFO nearly full.
    for (int c = 0; c < 7; c++) begin
      pair(200 + c, 1'b1);
      @(negedge clk);
    end
    check("pre_rst_stall", 32'(trace_stall), 32'h1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_pc", debug_wb_pc, 32'h0);
    check("async_rst_wen", 32'(debug_wb_rf_wen), 32'h0);
    check("async_rst_stall", 32'(trace_stall), 32'h0);
    check("async_rst_ovf", 32'(trace_overflow), 32'h0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", debug_wb_pc, 32'h0);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
